// File: rtl/frame_checker.sv
// Streaming frame checker: destination-MAC filter, 32-bit payload checksum and
// saturating frame statistics, configured and read through an 8-bit Avalon-MM window.
module frame_checker #(
  parameter int         DATA_WIDTH  = 16,
  parameter logic [7:0] IFG_DEFAULT = 8'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            writedata,
  input  logic                  write,
  input  logic                  chipselect,
  input  logic [7:0]            address,
  input  logic                  read,
  output logic [7:0]            readdata,
  input  logic [DATA_WIDTH-1:0] ingress_port_tdata,
  input  logic                  ingress_port_tvalid,
  output logic                  ingress_port_tready,
  input  logic                  ingress_port_tlast
);
  localparam int L = DATA_WIDTH / 16;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_t;

  state_t      state_q;
  logic [7:0]  mac_q [6];
  logic [7:0]  ifg_q, gap_q;
  logic        enable_q, promisc_q, bcast_q;
  logic [7:0]  status_q, frame_cnt_q, match_cnt_q, runt_cnt_q, readdata_q;
  logic [31:0] checksum_q, sum_q;
  logic [15:0] hw_idx_q;
  logic        eq_q, ff_q;

  logic        wr_en, clear_w, accept, last_beat;
  logic [15:0] mac_hw [4];
  logic [15:0] base_d, idx_d, lane_d, total_d;
  logic [31:0] sum_d;
  logic        eq_d, ff_d, runt_d, match_d;
  logic [7:0]  rdmux_d;

  assign wr_en     = chipselect & write;
  assign clear_w   = wr_en && (address == 8'd7) && writedata[3];
  assign accept    = ingress_port_tvalid & ingress_port_tready;
  assign last_beat = accept & ingress_port_tlast;
  assign readdata  = readdata_q;

  assign ingress_port_tready = (state_q == HDR) || (state_q == PAYLOAD) ||
                               ((state_q == IDLE) && enable_q);

  assign mac_hw[0] = {mac_q[1], mac_q[0]};
  assign mac_hw[1] = {mac_q[3], mac_q[2]};
  assign mac_hw[2] = {mac_q[5], mac_q[4]};
  assign mac_hw[3] = 16'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_q     <= '{default: 8'd0};
      ifg_q     <= IFG_DEFAULT;
      enable_q  <= 1'b0;
      promisc_q <= 1'b0;
      bcast_q   <= 1'b0;
    end else if (wr_en) begin
      if (address < 8'd6)
        mac_q[address[2:0]] <= writedata;
      else if (address == 8'd6)
        ifg_q <= writedata;
      else if (address == 8'd7)
        {bcast_q, promisc_q, enable_q} <= writedata[2:0];
    end
  end

  // A beat accepted in IDLE starts a fresh frame, so the accumulators restart from zero.
  always_comb begin
    lane_d = 16'd0;
    idx_d  = 16'd0;
    base_d = (state_q == IDLE) ? 16'd0 : hw_idx_q;
    sum_d  = (state_q == IDLE) ? 32'd0 : sum_q;
    eq_d   = (state_q == IDLE) ? 1'b1  : eq_q;
    ff_d   = (state_q == IDLE) ? 1'b1  : ff_q;
    for (int j = 0; j < L; j++) begin
      lane_d = ingress_port_tdata[16*j +: 16];
      idx_d  = base_d + 16'(j);
      if (idx_d < 16'd3) begin
        if (lane_d != mac_hw[idx_d[1:0]]) eq_d = 1'b0;
        if (lane_d != 16'hFFFF)           ff_d = 1'b0;
      end else if (idx_d >= 16'd7) begin
        sum_d = sum_d + {16'd0, lane_d};
      end
    end
    total_d = (base_d > 16'hFF00) ? base_d : base_d + 16'(L);
    runt_d  = total_d < 16'd7;
    match_d = !runt_d && (promisc_q || eq_d || (bcast_q && ff_d));
  end

  // Clear is applied after the completion update so it wins when both land together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hw_idx_q    <= 16'd0;
      sum_q       <= 32'd0;
      eq_q        <= 1'b1;
      ff_q        <= 1'b1;
      gap_q       <= 8'd0;
      status_q    <= 8'd0;
      checksum_q  <= 32'd0;
      frame_cnt_q <= 8'd0;
      match_cnt_q <= 8'd0;
      runt_cnt_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE, HDR, PAYLOAD: begin
          if (accept) begin
            hw_idx_q <= total_d;
            sum_q    <= sum_d;
            eq_q     <= eq_d;
            ff_q     <= ff_d;
            if (ingress_port_tlast) begin
              if (ifg_q != 8'd0) begin
                state_q <= GAP;
                gap_q   <= ifg_q;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q <= (total_d >= 16'd7) ? PAYLOAD : HDR;
            end
          end
        end
        GAP: begin
          if (gap_q <= 8'd1) state_q <= IDLE;
          else               gap_q   <= gap_q - 8'd1;
        end
        default: state_q <= IDLE;
      endcase

      if (last_beat) begin
        checksum_q  <= runt_d ? 32'd0 : sum_d;
        status_q    <= {5'd0, 1'b1, runt_d, match_d};
        frame_cnt_q <= frame_cnt_q + {7'd0, frame_cnt_q != 8'hFF};
        match_cnt_q <= match_cnt_q + {7'd0, match_d && (match_cnt_q != 8'hFF)};
        runt_cnt_q  <= runt_cnt_q + {7'd0, runt_d && (runt_cnt_q != 8'hFF)};
      end
      if (clear_w) begin
        status_q    <= 8'd0;
        frame_cnt_q <= 8'd0;
        match_cnt_q <= 8'd0;
        runt_cnt_q  <= 8'd0;
      end
    end
  end

  always_comb begin
    rdmux_d = 8'd0;
    case (address)
      8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5: rdmux_d = mac_q[address[2:0]];
      8'd6:  rdmux_d = ifg_q;
      8'd7:  rdmux_d = {5'd0, bcast_q, promisc_q, enable_q};
      8'd8:  rdmux_d = status_q;
      8'd9:  rdmux_d = checksum_q[7:0];
      8'd10: rdmux_d = checksum_q[15:8];
      8'd11: rdmux_d = checksum_q[23:16];
      8'd12: rdmux_d = checksum_q[31:24];
      8'd13: rdmux_d = frame_cnt_q;
      8'd14: rdmux_d = match_cnt_q;
      8'd15: rdmux_d = runt_cnt_q;
      default: rdmux_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  readdata_q <= 8'd0;
    else if (chipselect && read) readdata_q <= rdmux_d;
    else                         readdata_q <= 8'd0;
  end

endmodule

// File: tb/tb_frame_checker.sv
// Self-checking bench for frame_checker: a 16-bit and a 64-bit instance share the
// register bus; frame results are predicted from whole-frame halfword lists.
module tb_frame_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  writedata, address;
  logic        write, chipselect, read;
  logic [7:0]  rd16, rd64;
  logic [15:0] tdata16;
  logic [63:0] tdata64;
  logic        tvalid16, tvalid64, tlast16, tlast64, tready16, tready64;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mac_m [6];
  bit          en_m, promisc_m, bcast_m;
  int          fc_m [2];
  int          mc_m [2];
  int          rc_m [2];
  logic [7:0]  st_m [2];
  logic [31:0] cs_m [2];
  logic [15:0] frame_hw [$];

  frame_checker #(.DATA_WIDTH(16), .IFG_DEFAULT(8'd0)) dut16 (
    .clk(clk), .reset(rst_n), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .read(read), .readdata(rd16),
    .ingress_port_tdata(tdata16), .ingress_port_tvalid(tvalid16),
    .ingress_port_tready(tready16), .ingress_port_tlast(tlast16));

  frame_checker #(.DATA_WIDTH(64), .IFG_DEFAULT(8'd2)) dut64 (
    .clk(clk), .reset(rst_n), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .read(read), .readdata(rd64),
    .ingress_port_tdata(tdata64), .ingress_port_tvalid(tvalid64),
    .ingress_port_tready(tready64), .ingress_port_tlast(tlast64));

  task automatic model_reset();
    for (int k = 0; k < 6; k++) mac_m[k] = 8'd0;
    en_m = 0; promisc_m = 0; bcast_m = 0;
    for (int s = 0; s < 2; s++) begin
      fc_m[s] = 0; mc_m[s] = 0; rc_m[s] = 0; st_m[s] = 8'd0; cs_m[s] = 32'd0;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      fc_m[s] = 0; mc_m[s] = 0; rc_m[s] = 0; st_m[s] = 8'd0;
    end
  endtask

  // Whole-frame prediction from the halfword list and the configured registers.
  task automatic model_frame(input int sel);
    int n;
    bit runt, eq, ff, match;
    logic [31:0] cs;
    n = frame_hw.size();
    runt = (n < 7); eq = 1; ff = 1; cs = 32'd0;
    if (!runt) begin
      for (int k = 0; k < 3; k++) begin
        if (frame_hw[k] != {mac_m[2*k+1], mac_m[2*k]}) eq = 0;
        if (frame_hw[k] != 16'hFFFF) ff = 0;
      end
      for (int k = 7; k < n; k++) cs = cs + {16'd0, frame_hw[k]};
    end
    match = !runt && (promisc_m || eq || (bcast_m && ff));
    st_m[sel] = {5'd0, 1'b1, runt, match};
    cs_m[sel] = cs;
    if (fc_m[sel] < 255) fc_m[sel]++;
    if (match && mc_m[sel] < 255) mc_m[sel]++;
    if (runt && rc_m[sel] < 255) rc_m[sel]++;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input int sel, input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk);
    #1;
    d = sel ? rd64 : rd16;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic set_mac(input logic [47:0] m);
    for (int k = 0; k < 6; k++) begin
      mac_m[k] = m[8*k +: 8];
      bus_write(8'(k), m[8*k +: 8]);
    end
  endtask

  task automatic set_cfg(input bit en, input bit pr, input bit bc);
    en_m = en; promisc_m = pr; bcast_m = bc;
    bus_write(8'd7, {5'd0, bc, pr, en});
  endtask

  task automatic clear_counters();
    bus_write(8'd7, {4'd0, 1'b1, bcast_m, promisc_m, en_m});
    model_clear();
  endtask

  task automatic read_results(input int sel, output logic [7:0] st, output logic [31:0] cs,
                              output logic [7:0] fc, output logic [7:0] mc, output logic [7:0] rc);
    logic [7:0] b;
    bus_read(sel, 8'd8, st);
    for (int k = 0; k < 4; k++) begin
      bus_read(sel, 8'(9 + k), b);
      cs[8*k +: 8] = b;
    end
    bus_read(sel, 8'd13, fc);
    bus_read(sel, 8'd14, mc);
    bus_read(sel, 8'd15, rc);
  endtask

  // kind 0 = matching header, 1 = broadcast header, otherwise random header
  task automatic build_frame(input int n, input int kind);
    frame_hw.delete();
    for (int k = 0; k < n; k++) begin
      if (k < 3 && kind == 0)      frame_hw.push_back({mac_m[2*k+1], mac_m[2*k]});
      else if (k < 3 && kind == 1) frame_hw.push_back(16'hFFFF);
      else                         frame_hw.push_back(16'($urandom));
    end
  endtask

  task automatic send_frame(input int sel, input bit clear_on_last);
    int nb, lanes, wait_cnt;
    lanes = sel ? 4 : 1;
    nb = frame_hw.size() / lanes;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      if (sel) begin
        for (int j = 0; j < 4; j++) tdata64[16*j +: 16] = frame_hw[4*b + j];
        tvalid64 = 1'b1; tlast64 = (b == nb - 1);
      end else begin
        tdata16 = frame_hw[b];
        tvalid16 = 1'b1; tlast16 = (b == nb - 1);
      end
      if (clear_on_last && b == nb - 1) begin
        chipselect = 1'b1; write = 1'b1; address = 8'd7;
        writedata = {4'd0, 1'b1, bcast_m, promisc_m, en_m};
      end
      wait_cnt = 0;
      while (((sel ? tready64 : tready16) !== 1'b1) && wait_cnt < 200) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (wait_cnt >= 200) begin
        checks++; failures++;
        $display("[TB] FAIL tready_timeout dut=%0d beat=%0d got=0 want=1", sel, b);
      end
      @(posedge clk);
      #1;
    end
    tvalid16 = 1'b0; tlast16 = 1'b0; tvalid64 = 1'b0; tlast64 = 1'b0;
    chipselect = 1'b0; write = 1'b0;
    model_frame(sel);
    if (clear_on_last) model_clear();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    checks++;
    if (tready16 !== 1'b0 || tready64 !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_tready got=%b%b want=00", tready16, tready64);
    end
    checks++;
    if (rd16 !== 8'd0) begin failures++; $display("[TB] FAIL reset_readdata got=%h want=00", rd16); end
    bus_read(0, 8'd0, d);
    checks++;
    if (d !== 8'd0) begin failures++; $display("[TB] FAIL reset_mac0 got=%h want=00", d); end
    bus_read(0, 8'd6, d);
    checks++;
    if (d !== 8'd0) begin failures++; $display("[TB] FAIL reset_ifg16 got=%h want=00", d); end
    bus_read(1, 8'd6, d);
    checks++;
    if (d !== 8'd2) begin failures++; $display("[TB] FAIL reset_ifg64 got=%h want=02", d); end
    bus_read(0, 8'd7, d);
    checks++;
    if (d !== 8'd0) begin failures++; $display("[TB] FAIL reset_ctrl got=%h want=00", d); end
    bus_read(0, 8'd8, d);
    checks++;
    if (d !== 8'd0) begin failures++; $display("[TB] FAIL reset_status got=%h want=00", d); end
    bus_read(0, 8'd13, d);
    checks++;
    if (d !== 8'd0) begin failures++; $display("[TB] FAIL reset_framecnt got=%h want=00", d); end
    bus_read(0, 8'd20, d);
    checks++;
    if (d !== 8'd0) begin failures++; $display("[TB] FAIL unmapped_read got=%h want=00", d); end
  endtask

  task automatic test_basic16();
    logic [7:0] st, fc, mc, rc;
    logic [31:0] cs;
    set_mac(48'h665544332211);
    set_cfg(1, 0, 0);
    build_frame(10, 0);
    frame_hw[7] = 16'd1; frame_hw[8] = 16'd2; frame_hw[9] = 16'd3;
    send_frame(0, 0);
    read_results(0, st, cs, fc, mc, rc);
    checks++;
    if (st !== 8'h05) begin failures++; $display("[TB] FAIL basic_status got=%h want=05", st); end
    checks++;
    if (cs !== 32'd6) begin failures++; $display("[TB] FAIL basic_checksum got=%h want=00000006", cs); end
    checks++;
    if (fc !== 8'd1) begin failures++; $display("[TB] FAIL basic_framecnt got=%0d want=1", fc); end
    checks++;
    if (mc !== 8'd1) begin failures++; $display("[TB] FAIL basic_matchcnt got=%0d want=1", mc); end
  endtask

  task automatic test_wide64();
    logic [7:0] st, fc, mc, rc;
    logic [31:0] cs;
    build_frame(12, 0);
    for (int k = 7; k < 12; k++) frame_hw[k] = 16'hFFFF;
    send_frame(1, 0);
    read_results(1, st, cs, fc, mc, rc);
    checks++;
    if (cs !== 32'h0004FFFB) begin failures++; $display("[TB] FAIL wide_checksum got=%h want=0004fffb", cs); end
    checks++;
    if (st !== 8'h05) begin failures++; $display("[TB] FAIL wide_status got=%h want=05", st); end
    checks++;
    if (mc !== 8'd1) begin failures++; $display("[TB] FAIL wide_matchcnt got=%0d want=1", mc); end
  endtask

  task automatic test_runt_bcast();
    logic [7:0] st, fc, mc, rc;
    logic [31:0] cs;
    build_frame(5, 0);
    send_frame(0, 0);
    read_results(0, st, cs, fc, mc, rc);
    checks++;
    if (rc !== 8'd1) begin failures++; $display("[TB] FAIL runt_count got=%0d want=1", rc); end
    checks++;
    if (st !== 8'h06) begin failures++; $display("[TB] FAIL runt_status got=%h want=06", st); end
    checks++;
    if (cs !== 32'd0) begin failures++; $display("[TB] FAIL runt_checksum got=%h want=0", cs); end
    set_cfg(1, 0, 1);
    build_frame(8, 1);
    send_frame(0, 0);
    bus_read(0, 8'd8, st);
    checks++;
    if (st !== 8'h05) begin failures++; $display("[TB] FAIL bcast_accept got=%h want=05", st); end
    set_cfg(1, 0, 0);
    build_frame(8, 1);
    send_frame(0, 0);
    bus_read(0, 8'd8, st);
    checks++;
    if (st !== 8'h04) begin failures++; $display("[TB] FAIL bcast_reject got=%h want=04", st); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fc;
    bus_write(8'd6, 8'd3);
    build_frame(8, 0);
    send_frame(0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (tready16 !== (k < 3 ? 1'b0 : 1'b1)) begin
        failures++;
        $display("[TB] FAIL ifg_tready cycle=%0d got=%b want=%b", k + 1, tready16, (k < 3 ? 1'b0 : 1'b1));
      end
    end
    build_frame(9, 2);
    send_frame(0, 0);
    bus_write(8'd6, 8'd0);
    bus_read(0, 8'd13, fc);
    checks++;
    if (fc !== 8'(fc_m[0])) begin failures++; $display("[TB] FAIL ifg_framecnt got=%0d want=%0d", fc, fc_m[0]); end
  endtask

  task automatic test_random();
    logic [7:0] st, fc, mc, rc;
    logic [31:0] cs;
    int sel, n;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) set_cfg(1, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
      if (i % 7 == 3) set_mac({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
      sel = $urandom_range(0, 1);
      n = sel ? 4 * $urandom_range(1, 5) : $urandom_range(1, 20);
      build_frame(n, $urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) frame_hw[$urandom_range(0, 2) % n] ^= 16'h0100;
      send_frame(sel, 0);
      read_results(sel, st, cs, fc, mc, rc);
      checks++;
      if (st !== st_m[sel]) begin failures++; $display("[TB] FAIL rand_status i=%0d got=%h want=%h", i, st, st_m[sel]); end
      checks++;
      if (cs !== cs_m[sel]) begin failures++; $display("[TB] FAIL rand_checksum i=%0d got=%h want=%h", i, cs, cs_m[sel]); end
      checks++;
      if (fc !== 8'(fc_m[sel]) || mc !== 8'(mc_m[sel]) || rc !== 8'(rc_m[sel])) begin
        failures++;
        $display("[TB] FAIL rand_counts i=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                 i, fc, mc, rc, fc_m[sel], mc_m[sel], rc_m[sel]);
      end
    end
  endtask

  task automatic test_saturation_clear();
    logic [7:0] st, fc, mc, rc, d;
    logic [31:0] cs;
    set_cfg(1, 0, 0);
    clear_counters();
    for (int i = 0; i < 300; i++) begin
      build_frame(8, 0);
      send_frame(0, 0);
    end
    read_results(0, st, cs, fc, mc, rc);
    checks++;
    if (fc !== 8'd255) begin failures++; $display("[TB] FAIL sat_framecnt got=%0d want=255", fc); end
    checks++;
    if (mc !== 8'd255) begin failures++; $display("[TB] FAIL sat_matchcnt got=%0d want=255", mc); end
    build_frame(8, 0);
    send_frame(0, 1);
    read_results(0, st, cs, fc, mc, rc);
    checks++;
    if (fc !== 8'd0 || mc !== 8'd0 || rc !== 8'd0 || st !== 8'd0) begin
      failures++;
      $display("[TB] FAIL clear_on_tlast got=%0d/%0d/%0d st=%h want=0/0/0 st=00", fc, mc, rc, st);
    end
    bus_read(0, 8'd7, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("[TB] FAIL ctrl_readback got=%h want=01", d); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] st, fc, mc, rc;
    logic [31:0] cs;
    build_frame(10, 0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      tdata16 = frame_hw[b]; tvalid16 = 1'b1; tlast16 = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if (tready16 !== 1'b1) begin failures++; $display("[TB] FAIL hdr_tready got=%b want=1", tready16); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tready16 !== 1'b0) begin failures++; $display("[TB] FAIL reset_tready_now got=%b want=0", tready16); end
    tvalid16 = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tready16 !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_tready got=%b want=0", tready16); end
    set_mac(48'h665544332211);
    set_cfg(1, 0, 0);
    build_frame(10, 0);
    send_frame(0, 0);
    read_results(0, st, cs, fc, mc, rc);
    checks++;
    if (fc !== 8'd1) begin failures++; $display("[TB] FAIL post_reset_framecnt got=%0d want=1", fc); end
    checks++;
    if (st !== 8'h05 || cs !== cs_m[0]) begin
      failures++; $display("[TB] FAIL post_reset_frame st=%h cs=%h want st=05 cs=%h", st, cs, cs_m[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; writedata = 8'd0; address = 8'd0; write = 1'b0; chipselect = 1'b0; read = 1'b0;
    tdata16 = 16'd0; tdata64 = 64'd0; tvalid16 = 1'b0; tvalid64 = 1'b0; tlast16 = 1'b0; tlast64 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic16();
    test_wide64();
    test_runt_bcast();
    test_back_to_back();
    test_random();
    test_saturation_clear();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
